// File: rtl/p2s_pkg.sv
// Shared types and elaboration helpers for the p2s_stream serial frame transmitter.
package p2s_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } p2s_state_e;

    // Bit counter width: must hold 0..data_bits.
    function automatic int bit_cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

    // Phase counter width: one full serial-clock period of 2*clk_div cycles.
    function automatic int div_cnt_width(input int clk_div);
        return (clk_div < 1) ? 1 : $clog2(2 * clk_div);
    endfunction

    // Parameter legality: a frame needs at least two bits and the divider at least one cycle.
    function automatic bit params_legal(input int data_bits, input int clk_div);
        return (data_bits >= 2) && (clk_div >= 1);
    endfunction

endpackage

// File: rtl/p2s_tick.sv
// Serial-clock phase generator: counts one bit period of 2*CLK_DIV cycles and
// tells the sequencer where the next edge lands inside the bit.
module p2s_tick
    import p2s_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_start,
    output logic s_clk_next,
    output logic half_end
);

    localparam int            CW       = div_cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Phase counter: wraps every bit period, cleared on every sequencer state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The coming edge starts a new bit when the period is exhausted.
    assign bit_start  = (cnt_r == CNT_LAST);
    // s_clk is high for counts CLK_DIV..2*CLK_DIV-1, so look one count ahead.
    assign s_clk_next = (cnt_r >= CNT_HALF) && (cnt_r != CNT_LAST);
    // End of a CLK_DIV-long phase (used by CLEAR and LATCH).
    assign half_end   = (cnt_r == CNT_HALF);

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial frame transmitter for chained 74HC164/595-style boards:
// optional chain clear, divided serial clock, MSB/LSB-first data, latch strobe.
module p2s_stream
    import p2s_pkg::*;
#(
    parameter int DATA_BITS   = 16,
    parameter int MSB_FIRST   = 1,
    parameter int CLK_DIV     = 2,
    parameter int CLEAR_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pdata,
    output logic                 ready,
    output logic                 done,
    output logic                 s_clk,
    output logic                 s_dat,
    output logic                 s_clrn,
    output logic                 s_latch
);

    localparam int            BW       = bit_cnt_width(DATA_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    if (!params_legal(DATA_BITS, CLK_DIV)) begin : g_bad_params
        $error("p2s_stream: DATA_BITS must be >= 2 and CLK_DIV >= 1");
    end

    p2s_state_e           state_r;
    p2s_state_e           state_s;
    logic [DATA_BITS-1:0] sh_r;
    logic [DATA_BITS-1:0] sh_s;
    logic [BW-1:0]        bit_cnt_r;
    logic [BW-1:0]        bit_cnt_s;
    logic                 accept_s;
    logic                 head_s;

    logic                 bit_start_s;
    logic                 s_clk_next_s;
    logic                 half_end_s;
    logic                 tick_en_s;
    logic                 tick_clr_s;

    logic                 ready_r,   ready_s;
    logic                 done_r,    done_s;
    logic                 s_clk_r,   s_clk_s;
    logic                 s_dat_r,   s_dat_s;
    logic                 s_clrn_r,  s_clrn_s;
    logic                 s_latch_r, s_latch_s;

    assign accept_s   = start && ready_r && (state_r == ST_IDLE);
    assign tick_en_s  = (state_r != ST_IDLE);
    assign tick_clr_s = (state_s != state_r) || (state_r == ST_IDLE);

    p2s_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .en         (tick_en_s),
        .clr        (tick_clr_s),
        .bit_start  (bit_start_s),
        .s_clk_next (s_clk_next_s),
        .half_end   (half_end_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = (CLEAR_FIRST != 0) ? ST_CLEAR : ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (half_end_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_SHIFT: begin
                if (bit_start_s && (bit_cnt_r == BIT_LAST)) begin
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_LATCH: begin
                if (half_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Shift register and bit counter next values; the word is captured only on acceptance.
    always_comb begin
        sh_s      = sh_r;
        bit_cnt_s = bit_cnt_r;
        if (accept_s) begin
            sh_s      = pdata;
            bit_cnt_s = '0;
        end else if ((state_r == ST_SHIFT) && bit_start_s && (bit_cnt_r != BIT_LAST)) begin
            if (MSB_FIRST != 0) begin
                sh_s = {sh_r[DATA_BITS-2:0], 1'b0};
            end else begin
                sh_s = {1'b0, sh_r[DATA_BITS-1:1]};
            end
            bit_cnt_s = bit_cnt_r + BIT_ONE;
        end else begin
            sh_s      = sh_r;
            bit_cnt_s = bit_cnt_r;
        end
        head_s = (MSB_FIRST != 0) ? sh_s[DATA_BITS-1] : sh_s[0];
    end

    // Shift register and bit counter storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r      <= '0;
            bit_cnt_r <= '0;
        end else begin
            sh_r      <= sh_s;
            bit_cnt_r <= bit_cnt_s;
        end
    end

    // Output values for the coming edge, derived from the state being entered.
    always_comb begin
        ready_s   = (state_s == ST_IDLE);
        done_s    = (state_r == ST_LATCH) && (state_s == ST_IDLE);
        s_clk_s   = (state_r == ST_SHIFT) && (state_s == ST_SHIFT) && s_clk_next_s;
        s_clrn_s  = (state_s != ST_CLEAR);
        s_latch_s = (state_s == ST_LATCH);
        if (state_s == ST_SHIFT) begin
            if ((state_r != ST_SHIFT) || bit_start_s) begin
                s_dat_s = head_s;
            end else begin
                s_dat_s = s_dat_r;
            end
        end else begin
            s_dat_s = 1'b0;
        end
    end

    // Output registers: every pin is driven straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            s_clk_r   <= 1'b0;
            s_dat_r   <= 1'b0;
            s_clrn_r  <= 1'b1;
            s_latch_r <= 1'b0;
        end else begin
            ready_r   <= ready_s;
            done_r    <= done_s;
            s_clk_r   <= s_clk_s;
            s_dat_r   <= s_dat_s;
            s_clrn_r  <= s_clrn_s;
            s_latch_r <= s_latch_s;
        end
    end

    assign ready   = ready_r;
    assign done    = done_r;
    assign s_clk   = s_clk_r;
    assign s_dat   = s_dat_r;
    assign s_clrn  = s_clrn_r;
    assign s_latch = s_latch_r;

endmodule

// File: tb/tb_p2s_stream.sv
// Scoreboard bench for p2s_stream: three configurations, a shift-chain model per
// instance, expected chain contents queued at issue and compared at done.
module tb_p2s_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [3];
    logic [15:0] pdata_v [3];
    logic [2:0]  ready_w, done_w, s_clk_w, s_dat_w, s_clrn_w, s_latch_w;

    // Hand-derived per-instance figures: width, divider, clear, done latency.
    localparam int W_P   [3] = '{16, 8, 16};
    localparam int DIV_P [3] = '{2, 1, 3};
    localparam int CLR_P [3] = '{1, 0, 1};
    localparam int LAT_P [3] = '{68, 17, 102};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    always @(posedge clk) cyc <= cyc + 1;

    p2s_stream #(.DATA_BITS(16), .MSB_FIRST(1), .CLK_DIV(2), .CLEAR_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .pdata(pdata_v[0]),
        .ready(ready_w[0]), .done(done_w[0]), .s_clk(s_clk_w[0]), .s_dat(s_dat_w[0]),
        .s_clrn(s_clrn_w[0]), .s_latch(s_latch_w[0]));

    p2s_stream #(.DATA_BITS(8), .MSB_FIRST(0), .CLK_DIV(1), .CLEAR_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .pdata(pdata_v[1][7:0]),
        .ready(ready_w[1]), .done(done_w[1]), .s_clk(s_clk_w[1]), .s_dat(s_dat_w[1]),
        .s_clrn(s_clrn_w[1]), .s_latch(s_latch_w[1]));

    p2s_stream #(.DATA_BITS(16), .MSB_FIRST(1), .CLK_DIV(3), .CLEAR_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .pdata(pdata_v[2]),
        .ready(ready_w[2]), .done(done_w[2]), .s_clk(s_clk_w[2]), .s_dat(s_dat_w[2]),
        .s_clrn(s_clrn_w[2]), .s_latch(s_latch_w[2]));

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h, want %0h (t=%0t)", nm, idx, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx, input logic [15:0] v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic chk_reset(input int i);
        chk("rst_ready",   i, 32'(ready_w[i]),   32'd1);
        chk("rst_done",    i, 32'(done_w[i]),    32'd0);
        chk("rst_s_clk",   i, 32'(s_clk_w[i]),   32'd0);
        chk("rst_s_dat",   i, 32'(s_dat_w[i]),   32'd0);
        chk("rst_s_clrn",  i, 32'(s_clrn_w[i]),  32'd1);
        chk("rst_s_latch", i, 32'(s_latch_w[i]), 32'd0);
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!ready_w[i] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w[i]) chk("ready_timeout", i, 32'(ready_w[i]), 32'd1);
    endtask

    // Issue one frame; the expected chain content is queued for the monitor.
    task automatic send(input int i, input logic [15:0] word, input logic [15:0] chain_exp,
                        input logic first_bit);
        wait_ready(i);
        start_v[i] = 1'b1;
        pdata_v[i] = word;
        push_exp(i, chain_exp);
        @(negedge clk);
        start_v[i] = 1'b0;
        pdata_v[i] = ~word;
        repeat (CLR_P[i] * DIV_P[i]) @(negedge clk);
        chk("first_bit", i, 32'(s_dat_w[i]), 32'(first_bit));
        wait_ready(i);
    endtask

    // Monitor: chain model, serial timing and frame bookkeeping per instance.
    logic [15:0] chain     [3];
    int          rises     [3];
    int          clrn_cnt  [3];
    int          latch_cnt [3];
    int          acc       [3];
    int          high_len  [3];
    int          low_len   [3];
    int          stable    [3];
    logic        low_valid [3];
    logic        prev_sclk [3];
    logic        prev_rdy  [3];
    logic        prev_dat  [3];
    logic        dat_rise  [3];

    initial begin
        logic        sc, sd, rd, dn, cl, la, have;
        logic [15:0] e, m;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                sc = s_clk_w[i]; sd = s_dat_w[i]; rd = ready_w[i];
                dn = done_w[i];  cl = s_clrn_w[i]; la = s_latch_w[i];
                if (rst) begin
                    chain[i] = 16'h0000; rises[i] = 0; clrn_cnt[i] = 0; latch_cnt[i] = 0;
                    acc[i] = cyc; high_len[i] = 0; low_len[i] = 0; stable[i] = 0;
                    low_valid[i] = 1'b0; prev_sclk[i] = 1'b0; prev_rdy[i] = 1'b1;
                    prev_dat[i] = 1'b0; dat_rise[i] = 1'b0;
                end else begin
                    if (sd == prev_dat[i]) stable[i]++; else stable[i] = 1;
                    if (la) begin
                        chk("latch_vs_clrn", i, 32'(cl), 32'd1);
                        chk("latch_vs_sclk", i, 32'(sc), 32'd0);
                    end
                    if (sc && !prev_sclk[i]) begin
                        chain[i] = {chain[i][14:0], sd};
                        rises[i]++;
                        chk("dat_setup", i, 32'(stable[i] > DIV_P[i]), 32'd1);
                        if (low_valid[i]) chk("sclk_low_len", i, low_len[i], DIV_P[i]);
                        dat_rise[i] = sd;
                        high_len[i] = 1;
                    end else if (sc) begin
                        high_len[i]++;
                        chk("dat_hold", i, 32'(sd), 32'(dat_rise[i]));
                    end else if (prev_sclk[i]) begin
                        chk("sclk_high_len", i, high_len[i], DIV_P[i]);
                        low_len[i] = 1;
                        low_valid[i] = 1'b1;
                    end else begin
                        low_len[i]++;
                    end
                    if (!cl) clrn_cnt[i]++;
                    if (la) latch_cnt[i]++;
                    if (prev_rdy[i] && !rd) acc[i] = cyc;
                    if (dn) begin
                        have = 1'b0;
                        e = 16'h0000;
                        case (i)
                            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                        endcase
                        m = 16'((32'd1 << W_P[i]) - 32'd1);
                        chk("chain", i, 32'(chain[i] & m), have ? 32'(e) : 32'hFFFF_FFFF);
                        chk("done_latency", i, cyc - acc[i], LAT_P[i]);
                        chk("sclk_rises", i, rises[i], W_P[i]);
                        chk("clrn_cycles", i, clrn_cnt[i], CLR_P[i] * DIV_P[i]);
                        chk("latch_cycles", i, latch_cnt[i], DIV_P[i]);
                        chk("done_ready", i, 32'(rd), 32'd1);
                        chain[i] = 16'h0000; rises[i] = 0; clrn_cnt[i] = 0;
                        latch_cnt[i] = 0; low_valid[i] = 1'b0;
                    end
                    prev_sclk[i] = sc;
                    prev_rdy[i]  = rd;
                    prev_dat[i]  = sd;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog[0]: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            pdata_v[i] = 16'h0000;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i);
        #2 rst = 1'b0;

        // Default configuration, MSB first.
        send(0, 16'hA5C3, 16'hA5C3, 1'b1);

        // LSB first, no clear, divide by 1, 8 bits: first bit shifted lands in Q7.
        send(1, 16'h0001, 16'h0080, 1'b1);
        send(1, 16'h00B4, 16'h002D, 1'b0);

        // start held high: second word accepted in the done cycle.
        wait_ready(0);
        start_v[0] = 1'b1;
        pdata_v[0] = 16'h0001;
        push_exp(0, 16'h0001);
        push_exp(0, 16'h8000);
        @(negedge clk);
        chk("b2b_accept", 0, 32'(ready_w[0]), 32'd0);
        pdata_v[0] = 16'h8000;
        wait_ready(0);
        chk("b2b_done", 0, 32'(done_w[0]), 32'd1);
        @(negedge clk);
        chk("b2b_nogap", 0, 32'(ready_w[0]), 32'd0);
        start_v[0] = 1'b0;
        pdata_v[0] = 16'h0000;
        wait_ready(0);

        // start and pdata disturbed mid-shift: ignored, not queued.
        wait_ready(0);
        start_v[0] = 1'b1;
        pdata_v[0] = 16'h3C96;
        push_exp(0, 16'h3C96);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        start_v[0] = 1'b1;
        pdata_v[0] = 16'hFFFF;
        @(negedge clk);
        chk("busy_ready", 0, 32'(ready_w[0]), 32'd0);
        start_v[0] = 1'b0;
        pdata_v[0] = 16'h0000;
        wait_ready(0);
        repeat (5) @(negedge clk);
        chk("no_queued_start", 0, 32'(ready_w[0]), 32'd1);

        // Asynchronous reset during bit 7; the frame is discarded.
        wait_ready(0);
        start_v[0] = 1'b1;
        pdata_v[0] = 16'hFFFF;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_dat", 0, 32'(s_dat_w[0]), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset(0);
        @(negedge clk);
        #2 rst = 1'b0;
        send(0, 16'h5A3C, 16'h5A3C, 1'b0);

        // Divide-by-3 sweep.
        send(2, 16'hA5C3, 16'hA5C3, 1'b1);
        send(2, 16'h0F0F, 16'h0F0F, 1'b0);

        repeat (5) @(negedge clk);
        chk("queues_empty", 0, q0.size() + q1.size() + q2.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
